// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester round-robin arbiter issuing register file writes
//
// Ports:
//   CLK, Reset                      clock, async active-high reset
//   arb_enable                      permits new grants when high
//   reqN_valid/addr/data/ready      requester N write request (handshake on valid & ready)
//   Reg_Write/Reg_address3/
//   Reg_input_data                  register file write port, one cycle after acceptance
//   pending_mask                    one-hot of address being written, zero when idle
//   last_grant                      index of the most recently accepted requester
//   wr_count                        wrapping count of issued register file writes

module reg_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  arb_enable,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  Reg_Write,
    output logic [ADDR_WIDTH-1:0] Reg_address3,
    output logic [DATA_WIDTH-1:0] Reg_input_data,
    output logic [7:0]            pending_mask,
    output logic                  last_grant,
    output logic [15:0]           wr_count
);

    logic grant0;
    logic grant1;

    // Grant selection; a tie goes to the requester that did not win last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!Reset && arb_enable) begin
            if (req0_valid && req1_valid) begin
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Accepted request is issued the following cycle; Reset drops anything
    // captured but not yet counted.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Reg_Write      <= 1'b0;
            Reg_address3   <= '0;
            Reg_input_data <= '0;
            last_grant     <= 1'b1;
            wr_count       <= 16'h0000;
        end else begin
            Reg_Write <= grant0 | grant1;
            wr_count  <= wr_count + {15'h0000, Reg_Write};
            if (grant0) begin
                Reg_address3   <= req0_addr;
                Reg_input_data <= req0_data;
                last_grant     <= 1'b0;
            end else if (grant1) begin
                Reg_address3   <= req1_addr;
                Reg_input_data <= req1_data;
                last_grant     <= 1'b1;
            end
        end
    end

    always_comb begin
        pending_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            pending_mask[i] = Reg_Write && (32'(Reg_address3) == i);
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter

module tb_reg_write_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        arb_enable;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        Reg_Write;
    logic [2:0]  Reg_address3;
    logic [15:0] Reg_input_data;
    logic [7:0]  pending_mask;
    logic        last_grant;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .CLK(CLK), .Reset(Reset), .arb_enable(arb_enable),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .Reg_Write(Reg_Write), .Reg_address3(Reg_address3), .Reg_input_data(Reg_input_data),
        .pending_mask(pending_mask), .last_grant(last_grant), .wr_count(wr_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        Reset = 1'b1; arb_enable = 1'b1;
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h0101;
        req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 16'h0404;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b required 00", req0_ready, req1_ready); end
        n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b required 0", Reg_Write); end
        n_checks++; if (Reg_address3 !== 3'd0 || Reg_input_data !== 16'h0000) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h required 0/0000", Reg_address3, Reg_input_data); end
        n_checks++; if (pending_mask !== 8'h00 || wr_count !== 16'h0000) begin n_fail++; $display("FAIL reset_mask_count: got %h/%h required 00/0000", pending_mask, wr_count); end
        n_checks++; if (last_grant !== 1'b1) begin n_fail++; $display("FAIL reset_last_grant: got %b required 1", last_grant); end
        @(negedge CLK);
        Reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_tie_after_reset();
        @(negedge CLK);
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'h2222;
        #1;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL tie_first_grant: got %b%b required 10", req0_ready, req1_ready); end
        @(posedge CLK); #1;
        n_checks++; if (Reg_Write !== 1'b1 || Reg_address3 !== 3'd2 || Reg_input_data !== 16'h1111) begin n_fail++; $display("FAIL tie_write0: got %b/%h/%h required 1/2/1111", Reg_Write, Reg_address3, Reg_input_data); end
        n_checks++; if (pending_mask !== 8'h04 || last_grant !== 1'b0) begin n_fail++; $display("FAIL tie_mask0: got %h/%b required 04/0", pending_mask, last_grant); end
        @(negedge CLK);
        req0_valid = 1'b0;
        #1;
        n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL tie_second_grant: got %b required 1", req1_ready); end
        @(posedge CLK); #1;
        n_checks++; if (Reg_Write !== 1'b1 || Reg_address3 !== 3'd5 || Reg_input_data !== 16'h2222) begin n_fail++; $display("FAIL tie_write1: got %b/%h/%h required 1/5/2222", Reg_Write, Reg_address3, Reg_input_data); end
        n_checks++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL tie_count1: got %0d required 1", wr_count); end
        @(negedge CLK);
        req1_valid = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (Reg_Write !== 1'b0 || Reg_address3 !== 3'd5 || Reg_input_data !== 16'h2222) begin n_fail++; $display("FAIL tie_idle_hold: got %b/%h/%h required 0/5/2222", Reg_Write, Reg_address3, Reg_input_data); end
        n_checks++; if (wr_count !== 16'd2 || pending_mask !== 8'h00) begin n_fail++; $display("FAIL tie_count2: got %0d/%h required 2/00", wr_count, pending_mask); end
    endtask

    task automatic test_back_to_back();
        logic       exp_g;
        logic [2:0] exp_a;
        logic [15:0] exp_d;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            req0_valid = 1'b1; req0_addr = 3'(k);     req0_data = 16'hA000 + 16'(k);
            req1_valid = 1'b1; req1_addr = 3'(7 - k); req1_data = 16'hB000 + 16'(k);
            exp_g = (k % 2 == 1);
            exp_a = exp_g ? 3'(7 - k) : 3'(k);
            exp_d = exp_g ? 16'hB000 + 16'(k) : 16'hA000 + 16'(k);
            #1;
            n_checks++; if (req0_ready !== !exp_g || req1_ready !== exp_g) begin n_fail++; $display("FAIL rr_grant_%0d: got %b%b required %b%b", k, req0_ready, req1_ready, !exp_g, exp_g); end
            @(posedge CLK); #1;
            n_checks++; if (Reg_Write !== 1'b1 || Reg_address3 !== exp_a || Reg_input_data !== exp_d) begin n_fail++; $display("FAIL rr_write_%0d: got %b/%h/%h required 1/%h/%h", k, Reg_Write, Reg_address3, Reg_input_data, exp_a, exp_d); end
            n_checks++; if (wr_count !== 16'(2 + k)) begin n_fail++; $display("FAIL rr_count_%0d: got %0d required %0d", k, wr_count, 2 + k); end
        end
        @(negedge CLK);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (Reg_Write !== 1'b0 || wr_count !== 16'd8) begin n_fail++; $display("FAIL rr_end: got %b/%0d required 0/8", Reg_Write, wr_count); end
    endtask

    task automatic test_single_r1();
        @(negedge CLK);
        req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 16'hBEEF;
        #1;
        n_checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_r1_ready: got %b%b required 01", req0_ready, req1_ready); end
        @(posedge CLK); #1;
        n_checks++; if (Reg_Write !== 1'b1 || pending_mask !== 8'h80 || Reg_input_data !== 16'hBEEF) begin n_fail++; $display("FAIL single_r1_write: got %b/%h/%h required 1/80/beef", Reg_Write, pending_mask, Reg_input_data); end
        @(negedge CLK);
        req1_valid = 1'b0;
    endtask

    task automatic test_enable_low();
        @(negedge CLK);
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'h3333;
        @(posedge CLK); #1;
        @(negedge CLK);
        arb_enable = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h0C01;
        req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 16'h0C06;
        #1;
        n_checks++; if (Reg_Write !== 1'b1 || Reg_address3 !== 3'd3) begin n_fail++; $display("FAIL en_low_issue: got %b/%h required 1/3", Reg_Write, Reg_address3); end
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge CLK);
            #1;
            n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_ready_%0d: got %b%b required 00", k, req0_ready, req1_ready); end
            @(posedge CLK); #1;
            n_checks++; if (Reg_Write !== 1'b0) begin n_fail++; $display("FAIL en_low_wr_%0d: got %b required 0", k, Reg_Write); end
        end
        @(negedge CLK);
        arb_enable = 1'b1;
        #1;
        n_checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL en_resume: got %b%b required 01", req0_ready, req1_ready); end
        @(posedge CLK); #1;
        n_checks++; if (Reg_Write !== 1'b1 || Reg_address3 !== 3'd6 || Reg_input_data !== 16'h0C06) begin n_fail++; $display("FAIL en_resume_write: got %b/%h/%h required 1/6/0c06", Reg_Write, Reg_address3, Reg_input_data); end
        @(negedge CLK);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 16'h6666;
        @(posedge CLK); #1;
        @(negedge CLK);
        req0_valid = 1'b0;
        Reset = 1'b1;
        #1;
        n_checks++; if (Reg_Write !== 1'b0 || wr_count !== 16'h0000 || last_grant !== 1'b1 || pending_mask !== 8'h00) begin n_fail++; $display("FAIL mid_reset: got %b/%h/%b/%h required 0/0000/1/00", Reg_Write, wr_count, last_grant, pending_mask); end
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (Reg_Write !== 1'b0 || wr_count !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_release: got %b/%h required 0/0000", Reg_Write, wr_count); end
    endtask

    task automatic test_wrap();
        @(negedge CLK);
        req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 16'h0000;
        req1_valid = 1'b1; req1_addr = 3'd1; req1_data = 16'h0001;
        #1;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_first_tie: got %b%b required 10", req0_ready, req1_ready); end
        repeat (65536) @(posedge CLK);
        #1;
        n_checks++; if (wr_count !== 16'hFFFF || Reg_Write !== 1'b1) begin n_fail++; $display("FAIL wrap_preload: got %h/%b required ffff/1", wr_count, Reg_Write); end
        @(negedge CLK);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge CLK); #1;
        n_checks++; if (wr_count !== 16'h0000 || Reg_Write !== 1'b0) begin n_fail++; $display("FAIL wrap_rollover: got %h/%b required 0000/0", wr_count, Reg_Write); end
    endtask

    initial begin
        Reset = 1'b1; arb_enable = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        test_reset();
        test_tie_after_reset();
        test_back_to_back();
        test_single_r1();
        test_enable_low();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
